// File: rtl/nor_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : nor_bus_ctrl
//  Brief    : Wishbone B4 pipelined slave that queues single-word requests
//             and replays them as asynchronous parallel NOR-flash cycles with
//             clock-counted CE#/OE#/WE# timing and in-order ack/err returns.
//  Revision : 1.0 - initial release
// ============================================================================
module nor_bus_ctrl #(
    parameter int ADDRBITS   = 26,
    parameter int DATABITS   = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_CYCLES  = 7,
    parameter int WE_CYCLES  = 4,
    parameter int RY_TIMEOUT = 1024
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [ADDRBITS-1:0] wb_adr_i,
    input  logic [DATABITS-1:0] wb_dat_i,
    input  logic                wb_we_i,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    output logic                wb_ack_o,
    output logic [DATABITS-1:0] wb_dat_o,
    output logic                wb_stall_o,
    output logic                wb_err_o,
    input  logic                nor_ry_i,
    input  logic [DATABITS-1:0] nor_data_i,
    output logic [DATABITS-1:0] nor_data_o,
    output logic [ADDRBITS-1:0] nor_addr_o,
    output logic                nor_ce_o,
    output logic                nor_we_o,
    output logic                nor_oe_o,
    output logic                nor_data_oe
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENT_W   = 1 + ADDRBITS + DATABITS;
    localparam int MAX_A   = (RD_CYCLES > WE_CYCLES) ? RD_CYCLES : WE_CYCLES;
    localparam int CNT_MAX = (MAX_A > RY_TIMEOUT) ? MAX_A : RY_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RY  = 3'd1,
        S_READ     = 3'd2,
        S_WR_SETUP = 3'd3,
        S_WR_PULSE = 3'd4,
        S_WR_HOLD  = 3'd5,
        S_TURN     = 3'd6
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [ENT_W-1:0]    fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]      count_q;
    logic                fifo_full, fifo_empty, push, pop;
    logic                head_we;
    logic [ADDRBITS-1:0] head_adr;
    logic [DATABITS-1:0] head_dat;

    assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = wb_cyc_i & wb_stb_i & ~fifo_full;
    assign {head_we, head_adr, head_dat} = fifo_mem_q[rd_ptr_q];
    // Stall depends only on the registered fill level, never on stb.
    assign wb_stall_o = fifo_full;

    // FIFO pointers/level; dropping cyc discards every queued request.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (!wb_cyc_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Request storage; contents are only meaningful between the pointers.
    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {wb_we_i, wb_adr_i, wb_dat_i};
    end

    // ----------------------------------------------------------------- FSM
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cur_we_q, cur_we_d;
    logic [ADDRBITS-1:0] cur_adr_q, cur_adr_d;
    logic [DATABITS-1:0] cur_dat_q, cur_dat_d;
    logic                resp_q, resp_d;
    logic                ce_q, ce_d, oe_q, oe_d, we_q, we_d, doe_q, doe_d;
    logic [ADDRBITS-1:0] addr_q, addr_d;
    logic [DATABITS-1:0] wdat_q, wdat_d, rdat_q, rdat_d;
    logic                ack_q, ack_d, err_q, err_d;
    logic                start, sel_we;
    logic [ADDRBITS-1:0] sel_adr;
    logic [DATABITS-1:0] sel_dat;

    // Registers for the state machine and every pin-facing output.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cur_we_q  <= 1'b0;
            cur_adr_q <= '0;
            cur_dat_q <= '0;
            resp_q    <= 1'b0;
            ce_q      <= 1'b1;
            oe_q      <= 1'b1;
            we_q      <= 1'b1;
            doe_q     <= 1'b0;
            addr_q    <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_we_q  <= cur_we_d;
            cur_adr_q <= cur_adr_d;
            cur_dat_q <= cur_dat_d;
            resp_q    <= resp_d;
            ce_q      <= ce_d;
            oe_q      <= oe_d;
            we_q      <= we_d;
            doe_q     <= doe_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            rdat_q    <= rdat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic; resp_q remembers whether the current request may
    // still be answered (cleared the moment cyc drops).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_we_d  = cur_we_q;
        cur_adr_d = cur_adr_q;
        cur_dat_d = cur_dat_q;
        resp_d    = resp_q & wb_cyc_i;
        ce_d      = ce_q;
        oe_d      = oe_q;
        we_d      = we_q;
        doe_d     = doe_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        pop       = 1'b0;
        start     = 1'b0;
        sel_we    = cur_we_q;
        sel_adr   = cur_adr_q;
        sel_dat   = cur_dat_q;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && wb_cyc_i) begin
                    pop       = 1'b1;
                    resp_d    = 1'b1;
                    cur_we_d  = head_we;
                    cur_adr_d = head_adr;
                    cur_dat_d = head_dat;
                    sel_we    = head_we;
                    sel_adr   = head_adr;
                    sel_dat   = head_dat;
                    if (nor_ry_i) begin
                        start = 1'b1;
                    end else begin
                        state_d = S_WAIT_RY;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT_RY: begin
                // Nothing has reached the pins yet, so an abandoned cycle
                // can simply be dropped.
                if (!wb_cyc_i) begin
                    state_d = S_TURN;
                end else if (nor_ry_i) begin
                    start = 1'b1;
                end else if (cnt_q == CNT_W'(RY_TIMEOUT - 1)) begin
                    err_d   = resp_q;
                    state_d = S_TURN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_READ: begin
                if (cnt_q == CNT_W'(RD_CYCLES - 1)) begin
                    if (resp_q && wb_cyc_i) begin
                        rdat_d = nor_data_i;
                        ack_d  = 1'b1;
                    end
                    ce_d    = 1'b1;
                    oe_d    = 1'b1;
                    state_d = S_TURN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR_SETUP: begin
                we_d    = 1'b0;
                cnt_d   = '0;
                state_d = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (cnt_q == CNT_W'(WE_CYCLES - 1)) begin
                    we_d    = 1'b1;
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR_HOLD: begin
                ce_d    = 1'b1;
                doe_d   = 1'b0;
                ack_d   = resp_q & wb_cyc_i;
                state_d = S_TURN;
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                ce_d    = 1'b1;
                oe_d    = 1'b1;
                we_d    = 1'b1;
                doe_d   = 1'b0;
            end
        endcase

        // Common launch of a flash cycle from either IDLE or WAIT_RY.
        if (start) begin
            addr_d = sel_adr;
            ce_d   = 1'b0;
            cnt_d  = '0;
            if (sel_we) begin
                wdat_d  = sel_dat;
                doe_d   = 1'b1;
                state_d = S_WR_SETUP;
            end else begin
                oe_d    = 1'b0;
                doe_d   = 1'b0;
                state_d = S_READ;
            end
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign wb_dat_o    = rdat_q;
    assign nor_ce_o    = ce_q;
    assign nor_oe_o    = oe_q;
    assign nor_we_o    = we_q;
    assign nor_data_oe = doe_q;
    assign nor_addr_o  = addr_q;
    assign nor_data_o  = wdat_q;

endmodule
`default_nettype wire

// File: tb/tb_nor_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nor_bus_ctrl
//  Brief    : Self-checking bench for nor_bus_ctrl: directed scenarios plus a
//             randomized request stream checked against a transaction model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nor_bus_ctrl;

    localparam int AW  = 26;
    localparam int DW  = 16;
    localparam int RD  = 7;
    localparam int WE  = 4;
    localparam int RYT = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] adr = '0;
    logic [DW-1:0] dat = '0;
    logic          we = 1'b0, stb = 1'b0, cyc = 1'b0, ry = 1'b1;
    logic          ack, stall, err, ce, oe, wen, doe;
    logic [DW-1:0] dat_o, nor_din, nor_dout;
    logic [AW-1:0] nor_addr;
    logic          ovr_en = 1'b0;
    logic [DW-1:0] ovr_val = '0;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Flash content model: a fixed function of the address unless overridden.
    function automatic logic [DW-1:0] flash_fn(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hC3A5 ^ {a[25:16], 6'b000000};
    endfunction
    assign nor_din = ovr_en ? ovr_val : flash_fn(nor_addr);

    nor_bus_ctrl #(
        .ADDRBITS(AW), .DATABITS(DW), .FIFO_DEPTH(4),
        .RD_CYCLES(RD), .WE_CYCLES(WE), .RY_TIMEOUT(RYT)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .wb_adr_i(adr), .wb_dat_i(dat), .wb_we_i(we),
        .wb_stb_i(stb), .wb_cyc_i(cyc),
        .wb_ack_o(ack), .wb_dat_o(dat_o), .wb_stall_o(stall), .wb_err_o(err),
        .nor_ry_i(ry), .nor_data_i(nor_din), .nor_data_o(nor_dout),
        .nor_addr_o(nor_addr), .nor_ce_o(ce), .nor_we_o(wen), .nor_oe_o(oe),
        .nor_data_oe(doe)
    );

    typedef struct {
        int            start;
        int            stop;
        int            oe_lo;
        int            we_lo;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } bus_rec_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] dat;
    } ack_rec_t;

    typedef struct {
        bit            we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } req_t;

    bus_rec_t bus_q[$];
    ack_rec_t ack_q[$];
    int       err_q[$];
    bus_rec_t cur;
    bit       in_bus = 0;
    int       viol = 0;
    int       stall_cnt = 0;

    // Pin monitor: records each CE# low window and every ack/err pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_bus = 0;
            bus_q.delete();
            ack_q.delete();
            err_q.delete();
        end else begin
            if (!oe && !wen) viol++;
            if (doe && !oe) viol++;
            if ((!oe || !wen) && ce) viol++;
            if (stall) stall_cnt++;
            if (!ce) begin
                if (!in_bus) begin
                    in_bus = 1;
                    cur = '{start: cycle, stop: 0, oe_lo: 0, we_lo: 0,
                            wr: 1'b0, addr: nor_addr, wdata: '0};
                end
                if (!oe) cur.oe_lo++;
                if (!wen) begin
                    cur.we_lo++;
                    cur.wdata = nor_dout;
                end
                if (doe) cur.wr = 1'b1;
                cur.addr = nor_addr;
            end else if (in_bus) begin
                cur.stop = cycle;
                bus_q.push_back(cur);
                in_bus = 0;
            end
            if (ack) ack_q.push_back('{cyc: cycle, dat: dat_o});
            if (err) err_q.push_back(cycle);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc = 1'b0;
        stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    // Presents one request and returns the edge number where it was taken.
    task automatic send(input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int acc);
        acc = -1;
        cyc = 1'b1;
        stb = 1'b1;
        we  = w;
        adr = a;
        dat = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!stall) begin
                tick();
                acc = cycle;
                break;
            end
            tick();
        end
        stb = 1'b0;
        compared++;
        if (acc < 0) begin
            mismatched++;
            $display("FAIL accept_timeout: request adr=%h not accepted in 200 clocks", a);
        end
    endtask

    task automatic wait_acks(input int target, input int budget);
        for (int k = 0; k < budget && ack_q.size() < target; k++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        compared++;
        if ({ce, wen, oe, doe, ack, err, stall} !== 7'b1110000) begin
            mismatched++;
            $display("FAIL reset_strobes: got ce/we/oe/doe/ack/err/stall=%b want 1110000",
                     {ce, wen, oe, doe, ack, err, stall});
        end
        compared++;
        if (nor_addr !== '0 || nor_dout !== '0) begin
            mismatched++;
            $display("FAIL reset_bus: got addr=%h data=%h want 0/0", nor_addr, nor_dout);
        end
        compared++;
        if (dat_o !== '0) begin
            mismatched++;
            $display("FAIL reset_dat_o: got %h want 0000", dat_o);
        end
    endtask

    task automatic test_single_read();
        int n, na, nb;
        ry = 1'b1;
        ovr_en = 1'b1;
        ovr_val = 16'hBEEF;
        na = ack_q.size();
        nb = bus_q.size();
        tick();
        send(1'b0, 26'h0000123, '0, n);
        wait_acks(na + 1, 40);
        repeat (3) tick();
        ovr_en = 1'b0;
        compared++;
        if (ack_q.size() != na + 1) begin
            mismatched++;
            $display("FAIL read_ack_count: got %0d want 1", ack_q.size() - na);
        end else begin
            compared++;
            if (ack_q[na].cyc !== n + 1 + RD || ack_q[na].dat !== 16'hBEEF) begin
                mismatched++;
                $display("FAIL read_ack: got edge %0d data %h want edge %0d data beef",
                         ack_q[na].cyc - n, ack_q[na].dat, 1 + RD);
            end
        end
        compared++;
        if (bus_q.size() != nb + 1) begin
            mismatched++;
            $display("FAIL read_bus_count: got %0d want 1", bus_q.size() - nb);
        end else begin
            compared++;
            if (bus_q[nb].start !== n + 1 || bus_q[nb].oe_lo !== RD ||
                bus_q[nb].stop - bus_q[nb].start !== RD || bus_q[nb].addr !== 26'h123 ||
                bus_q[nb].wr !== 1'b0 || bus_q[nb].we_lo !== 0) begin
                mismatched++;
                $display("FAIL read_bus: got start+%0d oe_lo=%0d ce_lo=%0d addr=%h wr=%0b we_lo=%0d want +1 %0d %0d 123 0 0",
                         bus_q[nb].start - n, bus_q[nb].oe_lo, bus_q[nb].stop - bus_q[nb].start,
                         bus_q[nb].addr, bus_q[nb].wr, bus_q[nb].we_lo, RD, RD);
            end
        end
    endtask

    task automatic test_single_write();
        int n, na, nb;
        na = ack_q.size();
        nb = bus_q.size();
        send(1'b1, 26'h3FFFFFF, 16'hA55A, n);
        wait_acks(na + 1, 40);
        repeat (3) tick();
        compared++;
        if (ack_q.size() != na + 1) begin
            mismatched++;
            $display("FAIL write_ack_count: got %0d want 1", ack_q.size() - na);
        end else begin
            compared++;
            if (ack_q[na].cyc !== n + 3 + WE) begin
                mismatched++;
                $display("FAIL write_ack_edge: got N+%0d want N+%0d", ack_q[na].cyc - n, 3 + WE);
            end
        end
        compared++;
        if (bus_q.size() != nb + 1) begin
            mismatched++;
            $display("FAIL write_bus_count: got %0d want 1", bus_q.size() - nb);
        end else begin
            compared++;
            if (bus_q[nb].start !== n + 1 || bus_q[nb].we_lo !== WE || bus_q[nb].oe_lo !== 0 ||
                bus_q[nb].stop - bus_q[nb].start !== WE + 2 || !bus_q[nb].wr ||
                bus_q[nb].addr !== 26'h3FFFFFF || bus_q[nb].wdata !== 16'hA55A) begin
                mismatched++;
                $display("FAIL write_bus: got start+%0d we_lo=%0d oe_lo=%0d ce_lo=%0d wr=%0b addr=%h data=%h want +1 %0d 0 %0d 1 3ffffff a55a",
                         bus_q[nb].start - n, bus_q[nb].we_lo, bus_q[nb].oe_lo,
                         bus_q[nb].stop - bus_q[nb].start, bus_q[nb].wr, bus_q[nb].addr,
                         bus_q[nb].wdata, WE, WE + 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n0, n, na, nb, s0;
        logic [AW-1:0] a;
        na = ack_q.size();
        nb = bus_q.size();
        s0 = stall_cnt;
        for (int i = 0; i < 6; i++) begin
            a = AW'(32'h200 + 3 * i);
            send(1'b0, a, '0, n);
            if (i == 0) n0 = n;
        end
        wait_acks(na + 6, 200);
        repeat (3) tick();
        compared++;
        if (stall_cnt == s0) begin
            mismatched++;
            $display("FAIL b2b_stall: got no stall cycles want at least one");
        end
        compared++;
        if (ack_q.size() != na + 6 || bus_q.size() != nb + 6) begin
            mismatched++;
            $display("FAIL b2b_count: got acks=%0d bus=%0d want 6/6",
                     ack_q.size() - na, bus_q.size() - nb);
        end else begin
            compared++;
            if (ack_q[na].cyc !== n0 + 1 + RD) begin
                mismatched++;
                $display("FAIL b2b_first_ack: got N+%0d want N+%0d", ack_q[na].cyc - n0, 1 + RD);
            end
            for (int i = 0; i < 6; i++) begin
                a = AW'(32'h200 + 3 * i);
                compared++;
                if (ack_q[na + i].dat !== flash_fn(a) || bus_q[nb + i].addr !== a) begin
                    mismatched++;
                    $display("FAIL b2b_data[%0d]: got data %h addr %h want %h %h",
                             i, ack_q[na + i].dat, bus_q[nb + i].addr, flash_fn(a), a);
                end
                if (i > 0) begin
                    compared++;
                    if (bus_q[nb + i].start - bus_q[nb + i - 1].stop !== 2) begin
                        mismatched++;
                        $display("FAIL b2b_gap[%0d]: got %0d idle clocks want 2",
                                 i, bus_q[nb + i].start - bus_q[nb + i - 1].stop);
                    end
                end
            end
        end
    endtask

    task automatic test_ry_timeout();
        int n, na, nb, ne;
        na = ack_q.size();
        nb = bus_q.size();
        ne = err_q.size();
        ry = 1'b0;
        send(1'b0, 26'h55, '0, n);
        for (int k = 0; k < RYT + 50 && err_q.size() == ne; k++) tick();
        repeat (5) tick();
        compared++;
        if (err_q.size() != ne + 1 || ack_q.size() != na || bus_q.size() != nb || in_bus) begin
            mismatched++;
            $display("FAIL ry_timeout: got errs=%0d acks=%0d bus=%0d want 1/0/0",
                     err_q.size() - ne, ack_q.size() - na, bus_q.size() - nb);
        end else begin
            compared++;
            if (err_q[ne] < n + RYT || err_q[ne] > n + RYT + 2) begin
                mismatched++;
                $display("FAIL ry_err_edge: got N+%0d want N+%0d..N+%0d",
                         err_q[ne] - n, RYT, RYT + 2);
            end
        end
        ry = 1'b1;
        send(1'b0, 26'h77, '0, n);
        wait_acks(na + 1, 40);
        tick();
        compared++;
        if (ack_q.size() != na + 1) begin
            mismatched++;
            $display("FAIL ry_recover_count: got %0d acks want 1", ack_q.size() - na);
        end else begin
            compared++;
            if (ack_q[na].dat !== flash_fn(26'h77) || ack_q[na].cyc !== n + 1 + RD) begin
                mismatched++;
                $display("FAIL ry_recover: got data %h edge N+%0d want %h N+%0d",
                         ack_q[na].dat, ack_q[na].cyc - n, flash_fn(26'h77), 1 + RD);
            end
        end
    endtask

    task automatic test_cyc_drop();
        int n, na, nb, ne;
        na = ack_q.size();
        nb = bus_q.size();
        ne = err_q.size();
        send(1'b1, 26'h10, 16'h1111, n);
        send(1'b1, 26'h11, 16'h2222, n);
        send(1'b1, 26'h12, 16'h3333, n);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!wen) break;
        end
        tick();
        cyc = 1'b0;
        repeat (40) tick();
        compared++;
        if (ack_q.size() != na || err_q.size() != ne || stall !== 1'b0) begin
            mismatched++;
            $display("FAIL drop_resp: got acks=%0d errs=%0d stall=%b want 0/0/0",
                     ack_q.size() - na, err_q.size() - ne, stall);
        end
        compared++;
        if (bus_q.size() != nb + 1) begin
            mismatched++;
            $display("FAIL drop_bus_count: got %0d bus cycles want 1", bus_q.size() - nb);
        end else begin
            compared++;
            if (!bus_q[nb].wr || bus_q[nb].we_lo !== WE || bus_q[nb].addr !== 26'h10 ||
                bus_q[nb].wdata !== 16'h1111 || bus_q[nb].stop - bus_q[nb].start !== WE + 2) begin
                mismatched++;
                $display("FAIL drop_inflight: got wr=%0b we_lo=%0d addr=%h data=%h ce_lo=%0d want 1 %0d 10 1111 %0d",
                         bus_q[nb].wr, bus_q[nb].we_lo, bus_q[nb].addr, bus_q[nb].wdata,
                         bus_q[nb].stop - bus_q[nb].start, WE, WE + 2);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int n;
        send(1'b1, 26'h2AB, 16'h5AA5, n);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!wen) break;
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({ce, wen, oe, doe, ack, stall} !== 6'b111000) begin
            mismatched++;
            $display("FAIL midwrite_reset: got ce/we/oe/doe/ack/stall=%b want 111000",
                     {ce, wen, oe, doe, ack, stall});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if ({ce, wen, oe, doe, ack, err, stall} !== 7'b1110000) begin
            mismatched++;
            $display("FAIL midwrite_after: got ce/we/oe/doe/ack/err/stall=%b want 1110000",
                     {ce, wen, oe, doe, ack, err, stall});
        end
        tick();
    endtask

    task automatic test_random();
        req_t          reqs[$];
        req_t          r;
        int            n, na, nb;
        logic [DW-1:0] last_rd;
        bit            have_rd;
        localparam int NREQ = 30;
        na = ack_q.size();
        nb = bus_q.size();
        ry = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            r.we  = 1'($urandom_range(0, 1));
            r.adr = AW'($urandom());
            r.dat = DW'($urandom());
            reqs.push_back(r);
            send(r.we, r.adr, r.dat, n);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_acks(na + NREQ, NREQ * 25);
        repeat (4) tick();
        compared++;
        if (ack_q.size() != na + NREQ || bus_q.size() != nb + NREQ) begin
            mismatched++;
            $display("FAIL rand_count: got acks=%0d bus=%0d want %0d",
                     ack_q.size() - na, bus_q.size() - nb, NREQ);
        end else begin
            have_rd = 0;
            last_rd = '0;
            for (int i = 0; i < NREQ; i++) begin
                r = reqs[i];
                if (!r.we) begin
                    last_rd = flash_fn(r.adr);
                    have_rd = 1;
                end
                if (have_rd) begin
                    compared++;
                    if (ack_q[na + i].dat !== last_rd) begin
                        mismatched++;
                        $display("FAIL rand_ack[%0d]: got %h want %h", i, ack_q[na + i].dat, last_rd);
                    end
                end
                compared++;
                if (bus_q[nb + i].wr !== r.we || bus_q[nb + i].addr !== r.adr ||
                    (r.we && (bus_q[nb + i].wdata !== r.dat || bus_q[nb + i].we_lo !== WE)) ||
                    (!r.we && bus_q[nb + i].oe_lo !== RD)) begin
                    mismatched++;
                    $display("FAIL rand_bus[%0d]: got wr=%0b addr=%h data=%h want wr=%0b addr=%h data=%h",
                             i, bus_q[nb + i].wr, bus_q[nb + i].addr, bus_q[nb + i].wdata,
                             r.we, r.adr, r.dat);
                end
                if (i > 0) begin
                    compared++;
                    if (bus_q[nb + i].start - bus_q[nb + i - 1].stop < 2 ||
                        ack_q[na + i].cyc <= ack_q[na + i - 1].cyc) begin
                        mismatched++;
                        $display("FAIL rand_order[%0d]: got gap %0d ack edges %0d,%0d want gap>=2 increasing",
                                 i, bus_q[nb + i].start - bus_q[nb + i - 1].stop,
                                 ack_q[na + i - 1].cyc, ack_q[na + i].cyc);
                    end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_ry_timeout();
        test_cyc_drop();
        test_reset_mid_write();
        test_random();
        compared++;
        if (viol != 0) begin
            mismatched++;
            $display("FAIL strobe_rules: got %0d violating cycles want 0", viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nor_bus_ctrl.md
Name: nor_bus_ctrl

Overview:
- Wishbone B4 pipelined slave that converts single-word read/write requests into asynchronous parallel NOR-flash bus cycles.
- Sits between the internal Wishbone fabric and the NOR flash pins.
- Buffers requests in a small FIFO, waits for the flash ready line, generates CE#/OE#/WE# timing from clock-cycle counters, and returns one ack (or err) per request, in order.

Parameters:
- ADDRBITS, 26, word address width (Wishbone and NOR).
- DATABITS, 16, data width.
- FIFO_DEPTH, 4, request FIFO entries (power of two).
- RD_CYCLES, 7, clocks OE#/CE# held low before read data is sampled (≥1).
- WE_CYCLES, 4, clocks WE# held low (≥1).
- RY_TIMEOUT, 1024, clocks to wait for nor_ry_i before erroring the request.

Ports:
- wb_clk_i  in  1  clock; all logic on its rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-low.
- wb_adr_i  in  ADDRBITS  request word address.
- wb_dat_i  in  DATABITS  write data.
- wb_we_i  in  1  1=write, 0=read.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  bus cycle.
- wb_ack_o  out  1  one-cycle completion pulse.
- wb_dat_o  out  DATABITS  read data, valid with ack.
- wb_stall_o  out  1  request not accepted.
- wb_err_o  out  1  one-cycle error completion (ready timeout).
- nor_ry_i  in  1  flash RY/BY#; 1 = ready.
- nor_data_i  in  DATABITS  flash data in.
- nor_data_o  out  DATABITS  flash data out.
- nor_addr_o  out  ADDRBITS  flash address.
- nor_ce_o, nor_we_o, nor_oe_o  out  1 each  active-low strobes.
- nor_data_oe  out  1  1 = drive nor_data_o onto pads.

Behaviour:
- Reset (wb_rst_i=0, async):
  - ce/we/oe = 1, nor_data_oe = 0, nor_addr_o = 0, nor_data_o = 0.
  - ack = err = 0, wb_dat_o = 0, wb_stall_o = 0.
  - FIFO emptied, FSM to IDLE; any in-flight bus cycle is aborted immediately.
- Accept:
  - A request is accepted on an edge where cyc & stb & !stall; {we, adr, dat} is pushed to the FIFO.
  - wb_stall_o = FIFO full (registered-equivalent, no combinational path from stb).
  - Push and pop on the same edge when full is allowed only if pop occurs; stall still reflects full.
- FSM states: IDLE, WAIT_RY, READ, WR_SETUP, WR_PULSE, WR_HOLD, TURN.
  - IDLE: FIFO non-empty → pop. If nor_ry_i=1 go directly to READ/WR_SETUP, else WAIT_RY. The popped entry is the head; no bypass beyond one cycle.
  - WAIT_RY: on nor_ry_i=1 → READ/WR_SETUP. If RY_TIMEOUT clocks elapse → wb_err_o pulse, no bus activity, → TURN.
  - READ: ce=oe=0, addr driven, nor_data_oe=0, for RD_CYCLES clocks. On the final edge: wb_dat_o ← nor_data_i, ack pulse, ce/oe → 1, → TURN.
  - WR_SETUP (1 clk): ce=0, addr and data driven, nor_data_oe=1, we=1.
  - WR_PULSE: we=0 for WE_CYCLES clocks.
  - WR_HOLD (1 clk): we=1, ce=0, data still driven. Ending edge: ce=1, nor_data_oe=0, ack pulse, → TURN.
  - TURN (1 clk): all strobes high, then IDLE.
- oe and we are never low simultaneously; nor_data_oe is never 1 while oe=0.
- Latency (accept at edge N, idle, ry=1):
  - Bus cycle starts at edge N+1 (IDLE pop edge = N+1).
  - Read ack at edge N+1+RD_CYCLES.
  - Write ack at edge N+3+WE_CYCLES.
  - Back-to-back transactions are separated by a 2-clock gap (TURN + IDLE).
- Ordering and completion:
  - Responses are in request order, exactly one ack or err per accepted request while cyc stays high.
  - wb_dat_o holds its last value otherwise.
- cyc dropped:
  - Queued, unstarted entries are flushed.
  - An in-flight flash cycle completes its full timing (flash safety) but its ack/err is suppressed.
  - Stall deasserts once the FIFO is flushed.
- nor_ry_i falling mid-cycle is ignored until the next transaction start.

Test Plan:
- Reset mid-write (during WR_PULSE) → next cycle ce=we=oe=1, nor_data_oe=0, ack=0, stall=0.
- Single read, adr=0x0000123, flash returns 0xBEEF, ry=1 → ce/oe low 7 clocks, addr=0x123, ack at N+8 with wb_dat_o=0xBEEF.
- Single write, adr=0x3FFFFFF, dat=0xA55A → nor_data_oe=1 with data 0xA55A, we low exactly 4 clocks inside ce low, ack at N+7, nor_data_oe never overlaps oe low.
- Issue 6 back-to-back reads with stb held → stall asserts after 4 queued; all 6 acks arrive in order with the correct data; 2-clock idle gap between flash cycles.
- ry held low 1024+ clocks on a read → no ce/oe activity, single err pulse, no ack. Then ry=1 with the next request → normal ack.
- 3 writes queued, cyc dropped during the first → first bus write completes its timing without ack; remaining two never appear on the bus.
